addsub_serial_ctrl: RTL

//   Bit-serial add/subtract sequencer for the adder/subtractor datapath.

---
 rtl/addsub_serial_ctrl_pkg.sv | 14 +
 rtl/addsub_serial_ctrl_fa_slice.sv | 14 +
 rtl/addsub_serial_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/addsub_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// controller state encodings and operation codes.
package addsub_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_ctrl_fa_slice.sv
// Combinational 1-bit full adder; the single slice the sequencer
// time-multiplexes across all operand bits.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Bit-serial add/subtract sequencer, LSB first, start/busy/done handshake.
// Optional signed-overflow flag enabled by defining ADDSUB_OVF_EN.
module addsub_serial_ctrl
    import addsub_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               slice_s;
    logic               slice_co;
    logic               last_bit;
    logic               accept;

    fa_slice u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    a_sh_d    = a;
                    // Subtract as A + ~B + 1: invert B here, seed the carry with 1.
                    b_sh_d    = b ^ {WIDTH{op_sub}};
                    carry_d   = (op_sub == OP_SUB);
                    bit_cnt_d = '0;
                end
            end
            ST_RUN: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                result_d  = {slice_s, result_q[WIDTH-1:1]};
                carry_d   = slice_co;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                cout_d  = carry_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // MSB carry-in is recovered as sum ^ a ^ b once the last bit has shifted in.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end
        if ((state_q == ST_RUN) && last_bit) begin
            a_msb_d = a_sh_q[0];
            b_msb_d = b_sh_q[0];
        end
        if (state_q == ST_DONE) begin
            ovf_d = a_msb_q ^ b_msb_q ^ result_q[WIDTH-1] ^ carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule
